// File: rtl/draw_pkg.sv
// Shared draw-path definitions: pixel bus widths, requester ids,
// arbiter state encoding and an index-width helper.
package draw_pkg;

    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

    localparam int REQ_PADDLE = 0;
    localparam int REQ_BALL   = 1;
    localparam int REQ_BRICK  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    // Index width for n entries, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of eligible, scanning upward
// from ptr and wrapping at N-1 back to 0.
module rr_pick
    import draw_pkg::*;
#(
    parameter int N = 3,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] eligible,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    int j;

    // Walk offsets from far to near so the nearest hit is written last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (eligible[j]) begin
                valid = 1'b1;
                idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Round-robin owner of the single VGA pixel-write port shared by
// the paddle, ball and brick draw controllers, with hold timeout.
module vga_draw_arbiter #(
    parameter int N_REQ    = 3,
    parameter int X_W      = draw_pkg::X_W,
    parameter int Y_W      = draw_pkg::Y_W,
    parameter int C_W      = draw_pkg::C_W,
    parameter int HOLD_MAX = 4096
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*X_W-1:0] x_in,
    input  logic [N_REQ*Y_W-1:0] y_in,
    input  logic [N_REQ*C_W-1:0] color_in,
    input  logic [N_REQ-1:0]     plot_in,
    output logic [N_REQ-1:0]     grant,
    output logic [X_W-1:0]       x,
    output logic [Y_W-1:0]       y,
    output logic [C_W-1:0]       colour,
    output logic                 plot,
    output logic                 busy,
    output logic                 timeout
);

    import draw_pkg::*;

    localparam int PW = idx_w(N_REQ);
    localparam int HW = $clog2(HOLD_MAX);
    localparam logic [PW-1:0] PTR_LAST  = PW'(N_REQ - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

    arb_state_e     state_q, state_d;
    logic [PW-1:0]  owner_q, owner_d;
    logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [N_REQ-1:0] lockout_q, lockout_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [C_W-1:0] colour_q, colour_d;
    logic           plot_q, plot_d;
    logic           timeout_q, timeout_d;

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] owner_oh;
    logic             pick_valid;
    logic [PW-1:0]    pick_idx;
    logic             owner_req;
    logic [PW-1:0]    next_ptr;
    logic [X_W-1:0]   sel_x;
    logic [Y_W-1:0]   sel_y;
    logic [C_W-1:0]   sel_c;
    logic             sel_plot;

    assign eligible = req & ~lockout_q;

    rr_pick #(
        .N (N_REQ),
        .W (PW)
    ) u_pick (
        .eligible (eligible),
        .ptr      (rr_ptr_q),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    // Decode the current owner and select its slice of the pixel buses.
    always_comb begin
        owner_oh = '0;
        sel_x    = '0;
        sel_y    = '0;
        sel_c    = '0;
        sel_plot = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == PW'(i)) begin
                owner_oh[i] = 1'b1;
                sel_x       = x_in[i*X_W +: X_W];
                sel_y       = y_in[i*Y_W +: Y_W];
                sel_c       = color_in[i*C_W +: C_W];
                sel_plot    = plot_in[i];
            end
        end
    end

    assign owner_req = |(req & owner_oh);
    assign next_ptr  = (owner_q == PTR_LAST) ? '0 : owner_q + 1'b1;

    // Next-state logic: grant, pass pixels, release or revoke.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        hold_d    = hold_q;
        lockout_d = lockout_q & req;
        x_d       = x_q;
        y_d       = y_q;
        colour_d  = colour_q;
        plot_d    = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_OWN;
                    owner_d = pick_idx;
                    hold_d  = '0;
                end
            end
            ST_OWN: begin
                if (!owner_req) begin
                    state_d  = ST_GAP;
                    rr_ptr_d = next_ptr;
                end else if (hold_q == HOLD_LAST) begin
                    state_d   = ST_GAP;
                    rr_ptr_d  = next_ptr;
                    timeout_d = 1'b1;
                    lockout_d = lockout_d | owner_oh;
                end else begin
                    x_d      = sel_x;
                    y_d      = sel_y;
                    colour_d = sel_c;
                    plot_d   = sel_plot;
                    hold_d   = hold_q + 1'b1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            hold_q    <= '0;
            lockout_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= '0;
            plot_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            hold_q    <= hold_d;
            lockout_q <= lockout_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            plot_q    <= plot_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant   = (state_q == ST_OWN) ? owner_oh : '0;
    assign busy    = (state_q == ST_OWN);
    assign x       = x_q;
    assign y       = y_q;
    assign colour  = colour_q;
    assign plot    = plot_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Directed bench for vga_draw_arbiter (HOLD_MAX=8).
// Inputs driven and outputs sampled on the falling clock edge.
module tb_vga_draw_arbiter;

    localparam int N  = 3;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CW = 3;
    localparam int HM = 8;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    req;
    logic [N*XW-1:0] x_in;
    logic [N*YW-1:0] y_in;
    logic [N*CW-1:0] color_in;
    logic [N-1:0]    plot_in;
    logic [N-1:0]    grant;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [CW-1:0]   colour;
    logic            plot;
    logic            busy;
    logic            timeout;

    int checks = 0;
    int errors = 0;

    vga_draw_arbiter #(
        .N_REQ    (N),
        .X_W      (XW),
        .Y_W      (YW),
        .C_W      (CW),
        .HOLD_MAX (HM)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .req      (req),
        .x_in     (x_in),
        .y_in     (y_in),
        .color_in (color_in),
        .plot_in  (plot_in),
        .grant    (grant),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .busy     (busy),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic set_bus(input int i, input int xv, input int yv,
                           input int cv, input logic pl);
        x_in[i*XW +: XW]     = XW'(xv);
        y_in[i*YW +: YW]     = YW'(yv);
        color_in[i*CW +: CW] = CW'(cv);
        plot_in[i]           = pl;
    endtask

    task automatic wait_grant();
        for (int c = 0; c < 8 && grant == '0; c++) @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        req = '0; plot_in = '0; x_in = '0; y_in = '0; color_in = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (grant !== 3'b000) begin
            errors++; $display("FAIL rst_grant got %b want 000", grant);
        end
        checks++;
        if ({x, y, colour} !== '0) begin
            errors++; $display("FAIL rst_pixel got %h/%h/%h want 0", x, y, colour);
        end
        checks++;
        if ({plot, busy, timeout} !== 3'b000) begin
            errors++;
            $display("FAIL rst_flags got %b want 000", {plot, busy, timeout});
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        set_bus(0, 75, 110, 7, 1'b1);
        req = 3'b001;
        @(negedge clk);
        checks++;
        if (grant !== 3'b001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL sg_grant got %b/%b want 001/1", grant, busy);
        end
        @(negedge clk);
        checks++;
        if (x !== 8'd75 || y !== 7'd110 || colour !== 3'd7 || plot !== 1'b1) begin
            errors++;
            $display("FAIL sg_pixel got %0d/%0d/%0d/%b want 75/110/7/1",
                     x, y, colour, plot);
        end
        req = 3'b000;
        @(negedge clk);
        checks++;
        if (grant !== 3'b000 || plot !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sg_release got %b/%b/%b want 000/0/0", grant, plot, busy);
        end
        req = 3'b001;
        @(negedge clk);
        checks++;
        if (grant !== 3'b000) begin
            errors++; $display("FAIL sg_gap got %b want 000", grant);
        end
        @(negedge clk);
        checks++;
        if (grant !== 3'b001) begin
            errors++; $display("FAIL sg_regrant got %b want 001", grant);
        end
        req = 3'b000;
        set_bus(0, 0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_seq [6];
        exp_seq = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
        req = 3'b111;
        for (int g = 0; g < 6; g++) begin
            wait_grant();
            checks++;
            if (grant !== exp_seq[g]) begin
                errors++;
                $display("FAIL rr_order[%0d] got %b want %b", g, grant, exp_seq[g]);
            end
            repeat (3) @(negedge clk);
            req = req & ~grant;
            @(negedge clk);
            req = 3'b111;
        end
        req = 3'b000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [N-1:0] seen;
        req = 3'b010;
        wait_grant();
        checks++;
        if (grant !== 3'b010) begin
            errors++; $display("FAIL to_grant got %b want 010", grant);
        end
        repeat (7) @(negedge clk);
        checks++;
        if (grant !== 3'b010 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_hold got %b/%b want 010/0", grant, timeout);
        end
        @(negedge clk);
        checks++;
        if (grant !== 3'b000 || busy !== 1'b0) begin
            errors++; $display("FAIL to_revoke got %b/%b want 000/0", grant, busy);
        end
        checks++;
        if (timeout !== 1'b1) begin
            errors++; $display("FAIL to_pulse got %b want 1", timeout);
        end
        @(negedge clk);
        checks++;
        if (timeout !== 1'b0) begin
            errors++; $display("FAIL to_pulse_len got %b want 0", timeout);
        end
        seen = '0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | grant;
        end
        checks++;
        if (seen !== 3'b000) begin
            errors++; $display("FAIL to_lockout got %b want 000", seen);
        end
        req = 3'b000;
        @(negedge clk);
        req = 3'b010;
        wait_grant();
        checks++;
        if (grant !== 3'b010) begin
            errors++; $display("FAIL to_regrant got %b want 010", grant);
        end
        req = 3'b000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_coincident();
        req = 3'b100;
        wait_grant();
        repeat (7) @(negedge clk);
        req = 3'b000;
        @(negedge clk);
        checks++;
        if (timeout !== 1'b0 || grant !== 3'b000) begin
            errors++;
            $display("FAIL co_release got %b/%b want 0/000", timeout, grant);
        end
        req = 3'b100;
        @(negedge clk);
        checks++;
        if (timeout !== 1'b0) begin
            errors++; $display("FAIL co_no_pulse got %b want 0", timeout);
        end
        wait_grant();
        checks++;
        if (grant !== 3'b100) begin
            errors++; $display("FAIL co_no_lockout got %b want 100", grant);
        end
        req = 3'b000;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_isolation();
        logic [4:0] pat;
        pat = 5'b01101;
        set_bus(0, 3, 3, 3, 1'b1);
        set_bus(2, 50, 20, 5, 1'b0);
        req = 3'b100;
        wait_grant();
        for (int k = 0; k < 5; k++) begin
            set_bus(2, 50 + k, 20, 5, pat[k]);
            @(negedge clk);
            checks++;
            if (x === 8'd3 || x !== 8'(50 + k)) begin
                errors++; $display("FAIL iso_x[%0d] got %0d want %0d", k, x, 50 + k);
            end
            checks++;
            if (plot !== pat[k]) begin
                errors++; $display("FAIL iso_plot[%0d] got %b want %b", k, plot, pat[k]);
            end
        end
        req = 3'b000;
        set_bus(0, 0, 0, 0, 1'b0);
        set_bus(2, 0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_async_reset();
        req = 3'b010;
        wait_grant();
        req = 3'b000;
        repeat (3) @(negedge clk);
        req = 3'b100;
        wait_grant();
        set_bus(2, 12, 12, 2, 1'b1);
        @(negedge clk);
        checks++;
        if (plot !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL ar_pre got %b/%b want 1/1", plot, busy);
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (grant !== 3'b000 || plot !== 1'b0 || busy !== 1'b0 || x !== 8'd0) begin
            errors++;
            $display("FAIL ar_clear got %b/%b/%b/%0d want 000/0/0/0",
                     grant, plot, busy, x);
        end
        @(negedge clk);
        resetn = 1'b1;
        set_bus(2, 0, 0, 0, 1'b0);
        req = 3'b110;
        wait_grant();
        checks++;
        if (grant !== 3'b010) begin
            errors++; $display("FAIL ar_ptr got %b want 010", grant);
        end
        req = 3'b000;
        repeat (3) @(negedge clk);
        req = 3'b100;
        wait_grant();
        checks++;
        if (grant !== 3'b100) begin
            errors++; $display("FAIL ar_req2 got %b want 100", grant);
        end
        req = 3'b000;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_coincident();
        test_isolation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got stalled want finish");
        $fatal(1);
    end

endmodule
